mem_copy_engine: RTL
====================

Name: mem_copy_engine

Overview:
- Block-move/fill sequencer directly upstream of the 256x8 data memory. It drives the memory's address, write-enable and write-data ports and consumes its combinational read data.
- Copies or fills up to 255 bytes without CPU involvement.
- The top level muxes the memory port between the CPU and this engine using busy.

Parameters:
- AW, 8, address width; memory depth is 2^AW.
- DW, 8, data width.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- start  input  1  request pulse; sampled only in IDLE.
- mode  input  1  0 = copy, 1 = fill.
- descending  input  1  0 = pointers increment, 1 = pointers decrement (overlapping copies).
- src_addr  input  AW  first source address (copy only).
- dst_addr  input  AW  first destination address.
- length  input  8  byte count, 0..255.
- fill_val  input  DW  fill byte (fill only).
- mem_rdata  input  DW  memory combinational read data.
- mem_addr  output  AW  memory address.
- mem_we  output  1  memory write enable.
- mem_wdata  output  DW  memory write data.
- busy  output  1  engine owns the memory port.
- done  output  1  one-cycle completion pulse.

Behaviour:
- States: IDLE, READ, WRITE, DONE.
- Registers: src_ptr, dst_ptr, remaining, mode_r, dir_r, fill_r, hold.
- Reset (reset=0, asynchronous):
  - state=IDLE; all pointers and registers cleared.
  - Outputs go low immediately, including mem_we.
- Outputs decode combinationally from registered state only. No input-to-output combinational path except mem_rdata into the hold register's D input.
- IDLE:
  - mem_addr=0, mem_we=0, mem_wdata=0, busy=0, done=0.
  - On a posedge with start=1, latch all operands.
  - Next state: DONE if length==0; WRITE if mode=1; otherwise READ.
- READ (copy only):
  - mem_addr=src_ptr, mem_we=0, busy=1.
  - At posedge: hold<=mem_rdata; src_ptr<=src_ptr±1 (mod 2^AW); go to WRITE.
- WRITE:
  - mem_addr=dst_ptr, mem_we=1, busy=1.
  - mem_wdata=hold in copy mode, fill_r in fill mode.
  - At posedge: dst_ptr<=dst_ptr±1 (mod 2^AW); remaining<=remaining-1.
  - Next state: if remaining==1, DONE; else READ (copy) or WRITE (fill).
- DONE:
  - done=1, busy=0, mem_we=0, mem_addr=0.
  - Next state is IDLE unconditionally; start is ignored in this cycle.
- Latency, with start accepted at edge 0:
  - Copy of N bytes: 2N busy cycles; done is high in cycle 2N+1.
  - Fill of N bytes: N busy cycles; done is high in cycle N+1.
  - length=0: done in cycle 1, no write ever issued.
- Pointer wrap: increments past 255 wrap to 0; decrements below 0 wrap to 255. No error is raised.
- Overlap: the engine does not detect overlap. Software selects descending=1 when dst>src within the region. Byte order follows the pointers exactly.
- start while busy, or in DONE: ignored; operands unchanged.
- Input changes after acceptance: operand inputs may change freely without effect.
- mem_rdata is ignored in all states except READ.
- Reset mid-operation: the transfer is abandoned.
  - No done pulse is produced.
  - Bytes already written stay written.
  - The write at the edge where reset asserts is not guaranteed.
- Exactly one memory write per WRITE cycle; never a write in READ, IDLE or DONE.

Test Plan:
- Ascending copy: preload mem[16..19]=A1,B2,C3,D4; start mode=0, src=16, dst=64, length=4 → mem[64..67]=A1,B2,C3,D4; busy high 8 cycles; done pulses in cycle 9; mem_we high on exactly 4 cycles.
- Fill: start mode=1, dst=200, length=3, fill_val=5A → mem[200..202]=5A; done in cycle 4; mem[199] and mem[203] unchanged.
- Overlapping descending copy: mem[10..13]=01,02,03,04; src=13, dst=15, length=4, descending=1 → mem[12..15]=01,02,03,04.
- Wrap and zero length: fill dst=254, length=4, fill_val=FF → mem[254], mem[255], mem[0], mem[1] = FF. Then length=0 → done in cycle 1, mem_we never asserted.
- Start while busy: during a length=10 copy, pulse start with new operands → original transfer completes unchanged; single done pulse.
- Reset mid-op: drive reset=0 during WRITE of byte 3 of a 6-byte copy → same-cycle mem_we=0, busy=0, state IDLE, no done. After release, a new start is accepted normally.

Source files
------------

// File: rtl/mem_copy_engine.sv
// Block copy / fill sequencer that owns the data memory port while busy.
// A copy alternates READ (capture byte) and WRITE (store byte); a fill stays in WRITE.
// Outputs are decoded from registered state only; mem_rdata reaches nothing but hold_d.
module mem_copy_engine #(
    parameter int unsigned AW = 8,
    parameter int unsigned DW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          mode,
    input  logic          descending,
    input  logic [AW-1:0] src_addr,
    input  logic [AW-1:0] dst_addr,
    input  logic [7:0]    length,
    input  logic [DW-1:0] fill_val,
    input  logic [DW-1:0] mem_rdata,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] src_ptr_q, src_ptr_d;
    logic [AW-1:0] dst_ptr_q, dst_ptr_d;
    logic [7:0]    remaining_q, remaining_d;
    logic          mode_q, mode_d;
    logic          dir_q, dir_d;
    logic [DW-1:0] fill_q, fill_d;
    logic [DW-1:0] hold_q, hold_d;

    // Pointer step; wraps modulo 2^AW in either direction.
    logic [AW-1:0] src_step, dst_step;
    assign src_step = dir_q ? src_ptr_q - AW'(1) : src_ptr_q + AW'(1);
    assign dst_step = dir_q ? dst_ptr_q - AW'(1) : dst_ptr_q + AW'(1);

    // State and operand registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            src_ptr_q   <= '0;
            dst_ptr_q   <= '0;
            remaining_q <= '0;
            mode_q      <= 1'b0;
            dir_q       <= 1'b0;
            fill_q      <= '0;
            hold_q      <= '0;
        end else begin
            state_q     <= state_d;
            src_ptr_q   <= src_ptr_d;
            dst_ptr_q   <= dst_ptr_d;
            remaining_q <= remaining_d;
            mode_q      <= mode_d;
            dir_q       <= dir_d;
            fill_q      <= fill_d;
            hold_q      <= hold_d;
        end
    end

    // Next-state and operand update logic.
    always_comb begin
        state_d     = state_q;
        src_ptr_d   = src_ptr_q;
        dst_ptr_d   = dst_ptr_q;
        remaining_d = remaining_q;
        mode_d      = mode_q;
        dir_d       = dir_q;
        fill_d      = fill_q;
        hold_d      = hold_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    src_ptr_d   = src_addr;
                    dst_ptr_d   = dst_addr;
                    remaining_d = length;
                    mode_d      = mode;
                    dir_d       = descending;
                    fill_d      = fill_val;
                    if (length == 8'd0) begin
                        state_d = StDone;
                    end else if (mode) begin
                        state_d = StWrite;
                    end else begin
                        state_d = StRead;
                    end
                end
            end
            StRead: begin
                hold_d    = mem_rdata;
                src_ptr_d = src_step;
                state_d   = StWrite;
            end
            StWrite: begin
                dst_ptr_d   = dst_step;
                remaining_d = remaining_q - 8'd1;
                if (remaining_q == 8'd1) begin
                    state_d = StDone;
                end else if (mode_q) begin
                    state_d = StWrite;
                end else begin
                    state_d = StRead;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Memory port and status outputs, decoded from state only.
    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state_q)
            StIdle: begin
            end
            StRead: begin
                mem_addr = src_ptr_q;
                busy     = 1'b1;
            end
            StWrite: begin
                mem_addr  = dst_ptr_q;
                mem_we    = 1'b1;
                mem_wdata = mode_q ? fill_q : hold_q;
                busy      = 1'b1;
            end
            StDone: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule
